// File: rtl/sys_ctrl.sv
// Command controller between the UART RX byte stream and the register file / ALU.
// Decodes framed commands, drives register-file and ALU strobes, and returns results to the TX FIFO.
module sys_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FUN_WIDTH     = 4,
    parameter int ALU_OUT_WIDTH = 2 * DATA_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [DATA_WIDTH-1:0]    WrData,
    input  logic [DATA_WIDTH-1:0]    RdData,
    input  logic                     RdData_valid,
    output logic                     ALU_EN,
    output logic [FUN_WIDTH-1:0]     ALU_FUN,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     ALU_OUT_VLD,
    output logic                     CLK_GATE_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    input  logic                     FIFO_FULL
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_TX_RD,
        S_ALU_A, S_ALU_B, S_ALU_FN, S_ALU_WAIT, S_TX_LSB, S_TX_MSB
    } state_t;

    state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0]    wr_addr_reg, wr_addr_next;
    logic [ALU_OUT_WIDTH-1:0] result_reg, result_next;

    logic [ADDR_WIDTH-1:0] address_next;
    logic [DATA_WIDTH-1:0] wr_data_next;
    logic [FUN_WIDTH-1:0]  alu_fun_next;
    logic [DATA_WIDTH-1:0] tx_data_next;
    logic                  wr_en_next, rd_en_next, alu_en_next, tx_vld_next, gate_next;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:      state_next = S_WR_ADDR;
                        CMD_RD:      state_next = S_RD_ADDR;
                        CMD_ALU_OP:  state_next = S_ALU_A;
                        CMD_ALU_NOP: state_next = S_ALU_FN;
                        default:     state_next = S_IDLE;
                    endcase
                end
            end
            S_WR_ADDR:  if (RX_D_VLD)     state_next = S_WR_DATA;
            S_WR_DATA:  if (RX_D_VLD)     state_next = S_IDLE;
            S_RD_ADDR:  if (RX_D_VLD)     state_next = S_RD_WAIT;
            S_RD_WAIT:  if (RdData_valid) state_next = S_TX_RD;
            S_TX_RD:    if (!FIFO_FULL)   state_next = S_IDLE;
            S_ALU_A:    if (RX_D_VLD)     state_next = S_ALU_B;
            S_ALU_B:    if (RX_D_VLD)     state_next = S_ALU_FN;
            S_ALU_FN:   if (RX_D_VLD)     state_next = S_ALU_WAIT;
            S_ALU_WAIT: if (ALU_OUT_VLD)  state_next = S_TX_LSB;
            S_TX_LSB:   if (!FIFO_FULL)   state_next = S_TX_MSB;
            S_TX_MSB:   if (!FIFO_FULL)   state_next = S_IDLE;
            default:                      state_next = S_IDLE;
        endcase
    end

    // Computes the next value of every registered output; data outputs hold between strobes.
    always_comb begin
        wr_en_next   = 1'b0;
        rd_en_next   = 1'b0;
        alu_en_next  = 1'b0;
        tx_vld_next  = 1'b0;
        address_next = Address;
        wr_data_next = WrData;
        alu_fun_next = ALU_FUN;
        tx_data_next = TX_P_DATA;
        wr_addr_next = wr_addr_reg;
        result_next  = result_reg;
        case (state_reg)
            S_WR_ADDR: begin
                if (RX_D_VLD) wr_addr_next = RX_P_DATA[ADDR_WIDTH-1:0];
            end
            S_WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_en_next   = 1'b1;
                    address_next = wr_addr_reg;
                    wr_data_next = RX_P_DATA;
                end
            end
            S_RD_ADDR: begin
                if (RX_D_VLD) begin
                    rd_en_next   = 1'b1;
                    address_next = RX_P_DATA[ADDR_WIDTH-1:0];
                end
            end
            S_RD_WAIT: begin
                if (RdData_valid) result_next = ALU_OUT_WIDTH'(RdData);
            end
            S_TX_RD, S_TX_LSB: begin
                if (!FIFO_FULL) begin
                    tx_vld_next  = 1'b1;
                    tx_data_next = result_reg[DATA_WIDTH-1:0];
                end
            end
            S_TX_MSB: begin
                if (!FIFO_FULL) begin
                    tx_vld_next  = 1'b1;
                    tx_data_next = result_reg[ALU_OUT_WIDTH-1:DATA_WIDTH];
                end
            end
            S_ALU_A, S_ALU_B: begin
                if (RX_D_VLD) begin
                    wr_en_next   = 1'b1;
                    address_next = (state_reg == S_ALU_A) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
                    wr_data_next = RX_P_DATA;
                end
            end
            S_ALU_FN: begin
                if (RX_D_VLD) begin
                    alu_en_next  = 1'b1;
                    alu_fun_next = RX_P_DATA[FUN_WIDTH-1:0];
                end
            end
            S_ALU_WAIT: begin
                if (ALU_OUT_VLD) result_next = ALU_OUT;
            end
            default: ;
        endcase
        // The ALU clock runs exactly while an operation is outstanding.
        gate_next = (state_next == S_ALU_WAIT);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Address     <= '0;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
            wr_addr_reg <= '0;
            result_reg  <= '0;
        end else begin
            Address     <= address_next;
            WrEn        <= wr_en_next;
            RdEn        <= rd_en_next;
            WrData      <= wr_data_next;
            ALU_EN      <= alu_en_next;
            ALU_FUN     <= alu_fun_next;
            CLK_GATE_EN <= gate_next;
            TX_P_DATA   <= tx_data_next;
            TX_D_VLD    <= tx_vld_next;
            wr_addr_reg <= wr_addr_next;
            result_reg  <= result_next;
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: directed scenarios plus randomized traffic, checked every cycle
// against a frame-level model (argument counting and a TX byte queue).
module tb_sys_ctrl;

    logic        CLK, RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [3:0]  Address;
    logic        WrEn, RdEn;
    logic [7:0]  WrData;
    logic [7:0]  RdData;
    logic        RdData_valid;
    logic        ALU_EN;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT;
    logic        ALU_OUT_VLD;
    logic        CLK_GATE_EN;
    logic [7:0]  TX_P_DATA;
    logic        TX_D_VLD;
    logic        FIFO_FULL;

    sys_ctrl dut (
        .CLK(CLK), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .Address(Address), .WrEn(WrEn), .RdEn(RdEn), .WrData(WrData),
        .RdData(RdData), .RdData_valid(RdData_valid),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .FIFO_FULL(FIFO_FULL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Frame-level reference model state and expected outputs
    logic [7:0] m_cmd = 8'h00;
    int         m_nargs = 0;
    bit         m_wait = 0;
    logic [3:0] m_lat_addr = 4'h0;
    logic [7:0] m_txq[$];
    logic       m_wr = 0, m_rd = 0, m_alu = 0, m_txv = 0, m_gate = 0;
    logic [3:0] m_addr = 4'h0, m_fun = 4'h0;
    logic [7:0] m_wrdata = 8'h00, m_txd = 8'h00;

    // Register-file / ALU responder state
    logic [7:0]  mem[16];
    int          rd_cnt = 0, alu_cnt = 0, rd_lat = 1, alu_lat = 1;
    logic [7:0]  rd_val = 8'h00;
    logic [15:0] alu_val = 16'h0, alu_force = 16'h0;
    bit          alu_force_en = 0, noise = 0;
    logic        rst_ctl = 1'b0, full_ctl = 1'b0;

    // Observed transactions for the literal checks
    logic [11:0] wr_log[$];
    logic [3:0]  rd_log[$];
    logic [3:0]  alu_log[$];
    logic [7:0]  tx_log[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            default: return {a, b} ^ 16'(f);
        endcase
    endfunction

    task automatic model_step();
        if (!RST) begin
            m_cmd = 8'h00; m_nargs = 0; m_wait = 0; m_lat_addr = 4'h0; m_txq.delete();
            m_wr = 0; m_rd = 0; m_alu = 0; m_txv = 0; m_gate = 0;
            m_addr = 4'h0; m_fun = 4'h0; m_wrdata = 8'h00; m_txd = 8'h00;
        end else begin
            m_wr = 0; m_rd = 0; m_alu = 0; m_txv = 0;
            if (m_txq.size() != 0) begin
                if (!FIFO_FULL) begin
                    m_txv = 1;
                    m_txd = m_txq.pop_front();
                    if (m_txq.size() == 0) m_cmd = 8'h00;
                end
            end else if (m_wait) begin
                if (m_cmd == 8'hBB) begin
                    if (RdData_valid) begin m_txq.push_back(RdData); m_wait = 0; end
                end else if (ALU_OUT_VLD) begin
                    m_txq.push_back(ALU_OUT[7:0]);
                    m_txq.push_back(ALU_OUT[15:8]);
                    m_wait = 0;
                    m_gate = 0;
                end
            end else if (RX_D_VLD) begin
                if (m_cmd == 8'h00) begin
                    if (RX_P_DATA inside {8'hAA, 8'hBB, 8'hCC, 8'hDD}) begin
                        m_cmd = RX_P_DATA;
                        m_nargs = 0;
                    end
                end else begin
                    m_nargs++;
                    case (m_cmd)
                        8'hAA: begin
                            if (m_nargs == 1) m_lat_addr = RX_P_DATA[3:0];
                            else begin
                                m_wr = 1; m_addr = m_lat_addr; m_wrdata = RX_P_DATA; m_cmd = 8'h00;
                            end
                        end
                        8'hBB: begin
                            m_rd = 1; m_addr = RX_P_DATA[3:0]; m_wait = 1;
                        end
                        8'hCC: begin
                            if (m_nargs <= 2) begin
                                m_wr = 1; m_addr = 4'(m_nargs - 1); m_wrdata = RX_P_DATA;
                            end else begin
                                m_alu = 1; m_fun = RX_P_DATA[3:0]; m_wait = 1; m_gate = 1;
                            end
                        end
                        default: begin
                            m_alu = 1; m_fun = RX_P_DATA[3:0]; m_wait = 1; m_gate = 1;
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("WrEn", int'(WrEn), int'(m_wr));
        chk("RdEn", int'(RdEn), int'(m_rd));
        chk("ALU_EN", int'(ALU_EN), int'(m_alu));
        chk("TX_D_VLD", int'(TX_D_VLD), int'(m_txv));
        chk("CLK_GATE_EN", int'(CLK_GATE_EN), int'(m_gate));
        chk("Address", int'(Address), int'(m_addr));
        chk("WrData", int'(WrData), int'(m_wrdata));
        chk("ALU_FUN", int'(ALU_FUN), int'(m_fun));
        chk("TX_P_DATA", int'(TX_P_DATA), int'(m_txd));
    endtask

    // Register file and ALU behaviour, driven from the strobes visible this cycle
    task automatic respond();
        RdData_valid = 1'b0;
        ALU_OUT_VLD  = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin RdData_valid = 1'b1; RdData = rd_val; end
        end else if (noise && $urandom_range(0, 19) == 0) begin
            RdData_valid = 1'b1; RdData = 8'($urandom);
        end
        if (alu_cnt > 0) begin
            alu_cnt--;
            if (alu_cnt == 0) begin ALU_OUT_VLD = 1'b1; ALU_OUT = alu_val; end
        end else if (noise && $urandom_range(0, 19) == 0) begin
            ALU_OUT_VLD = 1'b1; ALU_OUT = 16'($urandom);
        end
        if (WrEn) mem[Address] = WrData;
        if (RdEn) begin rd_val = mem[Address]; rd_cnt = rd_lat; end
        if (ALU_EN) begin
            alu_val = alu_force_en ? alu_force : alu_calc(mem[0], mem[1], ALU_FUN);
            alu_cnt = alu_lat;
        end
    endtask

    task automatic tick(input logic rxv, input logic [7:0] rxb, input bit chk_async = 0);
        @(negedge CLK);
        RST = rst_ctl;
        respond();
        RX_D_VLD  = rxv;
        RX_P_DATA = rxv ? rxb : 8'($urandom);
        FIFO_FULL = full_ctl;
        if (chk_async) begin
            #1;
            chk("async_rst_Address", int'(Address), 0);
            chk("async_rst_strobes", int'({WrEn, RdEn, ALU_EN, TX_D_VLD}), 0);
            chk("async_rst_gate", int'(CLK_GATE_EN), 0);
            chk("async_rst_data", int'({WrData, ALU_FUN, TX_P_DATA}), 0);
        end
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
        if (TX_D_VLD) tx_log.push_back(TX_P_DATA);
        if (WrEn)     wr_log.push_back({Address, WrData});
        if (RdEn)     rd_log.push_back(Address);
        if (ALU_EN)   alu_log.push_back(ALU_FUN);
    endtask

    task automatic send(input logic [7:0] b);
        tick(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic clear_logs();
        wr_log.delete(); rd_log.delete(); alu_log.delete(); tx_log.delete();
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_log.size() < n && k < budget) begin
            tick(1'b0, 8'h00);
            k++;
        end
        chk("tx_byte_count", tx_log.size(), n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cmds[4];
        cmds = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        RST = 1'b1; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; RdData = 8'h00; RdData_valid = 1'b0;
        ALU_OUT = 16'h0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
        #2 RST = 1'b0;

        // Reset state
        rst_ctl = 1'b0;
        tick(1'b0, 8'h00, 1);
        tick(1'b0, 8'h00);
        rst_ctl = 1'b1;
        idle(2);

        // Register write
        clear_logs();
        send(8'hAA); send(8'h05); send(8'h3C);
        idle(3);
        chk("wr_count", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("wr_addr_data", int'(wr_log[0]), 'h53C);
        chk("wr_other_strobes", rd_log.size() + alu_log.size() + tx_log.size(), 0);

        // Register read, data one cycle after RdEn
        clear_logs();
        rd_lat = 1;
        send(8'hBB); send(8'h05);
        wait_tx(1, 20);
        chk("rd_count", rd_log.size(), 1);
        if (rd_log.size() > 0) chk("rd_addr", int'(rd_log[0]), 5);
        if (tx_log.size() > 0) chk("rd_tx_byte", int'(tx_log[0]), 'h3C);

        // ALU with operands
        clear_logs();
        alu_lat = 3;
        send(8'hCC); send(8'h0A); send(8'h03); send(8'h00);
        chk("gate_on_alu_en", int'(CLK_GATE_EN), 1);
        wait_tx(2, 20);
        chk("alu_wr_count", wr_log.size(), 2);
        if (wr_log.size() > 1) begin
            chk("alu_wr_a", int'(wr_log[0]), 'h00A);
            chk("alu_wr_b", int'(wr_log[1]), 'h103);
        end
        if (alu_log.size() > 0) chk("alu_fun0", int'(alu_log[0]), 0);
        if (tx_log.size() > 1) begin
            chk("alu_tx_lsb", int'(tx_log[0]), 'h0D);
            chk("alu_tx_msb", int'(tx_log[1]), 'h00);
        end
        chk("gate_off_after", int'(CLK_GATE_EN), 0);

        // Back-pressure on the two result bytes
        clear_logs();
        alu_lat = 1; alu_force = 16'h1234; alu_force_en = 1;
        full_ctl = 1'b1;
        send(8'hDD); send(8'h02);
        idle(8);
        chk("stall_no_tx", tx_log.size(), 0);
        chk("stall_alu_fun", int'(ALU_FUN), 2);
        chk("stall_no_wr", wr_log.size(), 0);
        full_ctl = 1'b0;
        wait_tx(2, 20);
        if (tx_log.size() > 1) begin
            chk("bp_tx_lsb", int'(tx_log[0]), 'h34);
            chk("bp_tx_msb", int'(tx_log[1]), 'h12);
        end
        idle(3);
        chk("bp_tx_once", tx_log.size(), 2);
        alu_force_en = 0;

        // Unknown command byte ignored
        clear_logs();
        send(8'h55); idle(2);
        chk("ignore_0x55", wr_log.size() + rd_log.size() + alu_log.size() + tx_log.size(), 0);

        // Bytes during RD_WAIT dropped
        send(8'hAA); send(8'h07); send(8'h5A); idle(2);
        clear_logs();
        rd_lat = 6;
        send(8'hBB); send(8'h07);
        send(8'hAA); send(8'h03); send(8'h99);
        wait_tx(1, 30);
        if (tx_log.size() > 0) chk("rdwait_tx_byte", int'(tx_log[0]), 'h5A);
        idle(3);
        chk("rdwait_dropped", wr_log.size(), 0);

        // Reset while waiting for the ALU
        clear_logs();
        alu_lat = 50;
        send(8'hDD); send(8'h01);
        idle(2);
        chk("gate_in_wait", int'(CLK_GATE_EN), 1);
        rst_ctl = 1'b0;
        tick(1'b0, 8'h00, 1);
        tick(1'b0, 8'h00);
        rst_ctl = 1'b1;
        rd_cnt = 0; alu_cnt = 0;
        clear_logs();
        send(8'hAA); send(8'h01); send(8'hFF);
        idle(3);
        chk("post_rst_wr_count", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("post_rst_wr", int'(wr_log[0]), 'h1FF);
        chk("post_rst_no_tx", tx_log.size(), 0);

        // Randomized traffic against the model
        noise = 1;
        for (int i = 0; i < 3000; i++) begin
            logic       v;
            logic [7:0] b;
            full_ctl = ($urandom_range(0, 9) < 3);
            rd_lat   = $urandom_range(1, 4);
            alu_lat  = $urandom_range(1, 5);
            if ($urandom_range(0, 599) == 0) begin
                rst_ctl = 1'b0;
                tick(1'b0, 8'h00);
                tick(1'b0, 8'h00);
                rst_ctl = 1'b1;
                rd_cnt = 0; alu_cnt = 0;
            end
            v = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 1) == 0) ? cmds[$urandom_range(0, 3)] : 8'($urandom);
            tick(v, b);
        end
        noise = 0;
        full_ctl = 1'b0;
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
